// File: rtl/deframer_pkg.sv
// Shared types and constants for serial_frame_deframer.
// DEFRAMER_PARITY_EN adds one even-parity bit after every payload byte.
package deframer_pkg;

  typedef enum logic {HUNT, PAYLOAD} state_e;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEF_SYNC_WORD = 8'hA5;

`ifdef DEFRAMER_PARITY_EN
  localparam int WORD_BITS = BYTE_W + 1;
`else
  localparam int WORD_BITS = BYTE_W;
`endif

  function automatic logic even_par_err(input logic [BYTE_W-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

endpackage

// File: rtl/sipo_byte_collector.sv
// Serial-in/parallel-out collector: shift window plus a per-word bit counter.
// Serves as the hunt window and as the payload assembler.
module sipo_byte_collector
  import deframer_pkg::*;
#(
  parameter int BITS_PER_WORD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              cnt_en,
  input  logic              din,
  output logic [BYTE_W-1:0] nxt,
  output logic [BYTE_W-1:0] word,
  output logic              done
);

  // One bit fewer than a word is stored: the final bit is taken straight from din.
  localparam int STORE_W = BITS_PER_WORD - 1;
  localparam logic [3:0] LAST = 4'(BITS_PER_WORD - 1);

  logic [STORE_W-1:0] sr;
  logic [3:0]         bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) sr <= {sr[STORE_W-2:0], din};
      if (cnt_en) bit_cnt <= done ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  assign done = cnt_en && (bit_cnt == LAST);
  assign nxt  = {sr[BYTE_W-2:0], din};

  if (BITS_PER_WORD > BYTE_W) begin : g_par
    // din carries the parity bit; the data byte is already in the register.
    assign word = sr[BYTE_W-1:0];
  end else begin : g_nopar
    assign word = nxt;
  end

endmodule

// File: rtl/serial_frame_deframer.sv
// Hunts an MSB-first bitstream for SYNC_WORD, then emits PAYLOAD_BYTES bytes.
// DEFRAMER_PARITY_EN: each payload byte is followed by an even-parity bit.
module serial_frame_deframer
  import deframer_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int                PAYLOAD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              locked,
  output logic              parity_err
);

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  state_e            state;
  logic [3:0]        fill_cnt;
  logic [7:0]        byte_cnt;
  logic [BYTE_W-1:0] nxt;
  logic [BYTE_W-1:0] word;
  logic              done;
  logic              cnt_en;
  logic              sync_hit;
  logic              frame_end;

  assign cnt_en    = din_valid && (state == PAYLOAD);
  // fill_cnt gate keeps the reset-cleared window from matching a zero-heavy sync word.
  assign sync_hit  = din_valid && (state == HUNT) && (fill_cnt >= 4'd7) && (nxt == SYNC_WORD);
  assign frame_end = done && (byte_cnt == LAST_BYTE);

  sipo_byte_collector #(
    .BITS_PER_WORD(WORD_BITS)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (sync_hit || frame_end),
    .shift_en (din_valid),
    .cnt_en   (cnt_en),
    .din      (din),
    .nxt      (nxt),
    .word     (word),
    .done     (done)
  );

`ifdef DEFRAMER_PARITY_EN
  logic perr_q;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      fill_cnt    <= '0;
      byte_cnt    <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
`ifdef DEFRAMER_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
`ifdef DEFRAMER_PARITY_EN
      perr_q      <= 1'b0;
`endif
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (fill_cnt < 4'd8) fill_cnt <= fill_cnt + 4'd1;
            if (sync_hit) begin
              state       <= PAYLOAD;
              frame_start <= 1'b1;
              locked      <= 1'b1;
              byte_cnt    <= '0;
            end
          end
          PAYLOAD: begin
            if (done) begin
              byte_out   <= word;
              byte_valid <= 1'b1;
`ifdef DEFRAMER_PARITY_EN
              perr_q     <= even_par_err(word, din);
`endif
              if (frame_end) begin
                frame_done <= 1'b1;
                state      <= HUNT;
                locked     <= 1'b0;
                fill_cnt   <= '0;
                byte_cnt   <= '0;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deframer.sv
// Scoreboard bench: a queue-based bitstream model predicts strobes, a monitor checks them.
module tb_serial_frame_deframer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int PB = 4;
`ifdef DEFRAMER_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, frame_start, frame_done, locked, parity_err;

  serial_frame_deframer #(.SYNC_WORD(SYNC), .PAYLOAD_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
    .frame_done(frame_done), .locked(locked), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         fs, bv, fd, pe, lk;
    logic [7:0] b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int gapmode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: keep the last 8 hunt bits and the current payload word as bit queues.
  bit hunt[$];
  bit pay[$];
  bit m_locked = 0;
  int m_nbytes = 0;

  function automatic void model_reset();
    hunt.delete(); pay.delete(); m_locked = 0; m_nbytes = 0;
  endfunction

  function automatic void model(input bit b, input int due);
    exp_t e;
    logic [7:0] v;
    bit x;
    if (!m_locked) begin
      hunt.push_back(b);
      if (hunt.size() > 8) void'(hunt.pop_front());
      if (hunt.size() == 8) begin
        v = '0;
        foreach (hunt[i]) v = {v[6:0], hunt[i]};
        if (v == SYNC) begin
          e = '{cyc: due, fs: 1, bv: 0, fd: 0, pe: 0, lk: 1, b: 8'h00};
          q.push_back(e);
          m_locked = 1; m_nbytes = 0; pay.delete();
        end
      end
    end else begin
      pay.push_back(b);
      if (pay.size() == BPB) begin
        v = '0; x = 0;
        for (int i = 0; i < 8; i++) v = {v[6:0], pay[i]};
        foreach (pay[i]) x ^= pay[i];
        m_nbytes++;
        e = '{cyc: due, fs: 0, bv: 1, fd: (m_nbytes == PB), pe: (BPB == 9) ? x : 1'b0,
              lk: (m_nbytes != PB), b: v};
        q.push_back(e);
        pay.delete();
        if (m_nbytes == PB) begin m_locked = 0; hunt.delete(); end
      end
    end
  endfunction

  task automatic drive_bit(input bit b);
    @(negedge clk);
    din = b; din_valid = 1'b1;
    model(b, cyc + 1);
    if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 2) == 0)) begin
      @(negedge clk);
      din_valid = 1'b0; din = 1'($urandom);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) drive_bit(v[i]);
  endtask

  task automatic send_pay(input logic [7:0] v, input bit flip);
    send_bits(v, 8);
    if (BPB == 9) drive_bit((^v) ^ flip);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0; din = 1'($urandom);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_byte_out"}, byte_out, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expectation, on the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_strobe_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (!rst && (byte_valid || frame_start || frame_done || parity_err)) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {byte_valid, frame_start, frame_done, parity_err}, 0);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("frame_start", frame_start, e.fs);
          chk("byte_valid", byte_valid, e.bv);
          if (e.bv) chk("byte_out", byte_out, e.b);
          chk("frame_done", frame_done, e.fd);
          chk("parity_err", parity_err, e.pe);
          chk("locked", locked, e.lk);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl [4];
    #1 check_outputs_zero("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // basic frame with leading noise
    gapmode = 0;
    send_bits(8'hA0, 3);
    send_bits(SYNC, 8);
    send_pay(8'h3C, 0); send_pay(8'h81, 0); send_pay(8'hFF, 0); send_pay(8'h00, 0);
    idle(3);
    chk("locked_after_frame", locked, 0);

    // same stream with din_valid alternating
    gapmode = 1;
    send_bits(8'hA0, 3);
    send_bits(SYNC, 8);
    send_pay(8'h3C, 0); send_pay(8'h81, 0); send_pay(8'hFF, 0); send_pay(8'h00, 0);
    gapmode = 0;
    idle(3);

    // sync pattern inside the payload, then back-to-back frame
    send_bits(SYNC, 8);
    for (int i = 0; i < 4; i++) send_pay(8'hA5, 0);
    send_bits(SYNC, 8);
    send_pay(8'h01, 0); send_pay(8'h02, 0); send_pay(8'h04, 0); send_pay(8'h08, 0);
    idle(2);

    // mid-frame reset discards the partial frame
    send_bits(SYNC, 8);
    send_pay(8'hDE, 0); send_pay(8'hAD, 0);
    send_bits(8'hF0, 5);
    do_reset();
    send_bits(SYNC, 8);
    send_pay(8'h11, 0); send_pay(8'h22, 0); send_pay(8'h33, 0); send_pay(8'h44, 0);
    idle(2);

`ifdef DEFRAMER_PARITY_EN
    // correct parity on 3C, wrong parity on 81
    send_bits(SYNC, 8);
    send_bits(8'h3C, 8); drive_bit(1'b0);
    send_bits(8'h81, 8); drive_bit(1'b1);
    send_pay(8'h5A, 0); send_pay(8'h7E, 0);
    idle(2);
`endif

    // randomized frames with noise, gaps and parity faults
    for (int f = 0; f < 30; f++) begin
      gapmode = $urandom_range(0, 2);
      for (int n = $urandom_range(0, 12); n > 0; n--) drive_bit(1'($urandom));
      send_bits(SYNC, 8);
      for (int i = 0; i < PB; i++) pl[i] = 8'($urandom);
      for (int i = 0; i < PB; i++) send_pay(pl[i], ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    gapmode = 0;

    idle(20);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_deframer.md
Name: serial_frame_deframer

Overview:
- Downstream consumer of the 8-bit SISO shift register's serial output (MSB-first bitstream).
- Hunts the stream for a configurable 8-bit sync word, then assembles a fixed number of payload bytes.
- Emits each payload byte with a one-cycle valid strobe.
- Sits between the serial delay/shift stage and the byte-wide processing logic.

Parameters:
- SYNC_WORD, 8'hA5: sync pattern that marks the start of a frame; MSB is received first.
- PAYLOAD_BYTES, 4: number of payload bytes per frame; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled only on edges where this is high
- byte_out  output  8  assembled payload byte, MSB = first received bit
- byte_valid  output  1  one-cycle strobe; byte_out is valid
- frame_start  output  1  one-cycle strobe on sync detection
- frame_done  output  1  one-cycle strobe, coincident with the last payload byte_valid
- locked  output  1  high while in PAYLOAD state
- parity_err  output  1  one-cycle strobe on a parity failure (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-high.
  - On rst: state=HUNT; byte_out=0, byte_valid=0, frame_start=0, frame_done=0, locked=0, parity_err=0.
  - All internal counters and the shift window clear to 0.
- Edges where din_valid=0: hold all state and counters. All strobes deassert.
- Strobes: all registered, high for exactly one clk cycle after the edge that causes them.
- HUNT state:
  - On each valid bit: window <= {window[6:0], din}; fill_cnt saturates at 8.
  - Sync is detected when fill_cnt (before the update) >= 7 and {window[6:0], din} == SYNC_WORD.
  - This fill requirement prevents reset-zero false matches.
  - On detection: frame_start=1, go to PAYLOAD, bit_cnt=0, byte_cnt=0, locked=1 from the next cycle.
- PAYLOAD state:
  - On each valid bit: shreg <= {shreg[6:0], din}; bit_cnt increments.
  - On the 8th bit of a byte: byte_out <= {shreg[6:0], din}, byte_valid=1, bit_cnt=0, byte_cnt increments.
  - Latency: byte_valid rises one cycle after the 8th bit is sampled.
  - A sync pattern occurring inside the payload is ignored.
- Last byte (byte_cnt == PAYLOAD_BYTES-1 when it completes):
  - frame_done=1 together with byte_valid.
  - Return to HUNT with fill_cnt=0 and window=0; locked drops on the same edge.
- Back-to-back frames: the next frame's sync may begin on the very next valid bit. It needs 8 fresh bits.
- byte_out holds its last value between strobes.
- Reset mid-frame: outputs clear immediately. The partial frame is discarded with no frame_done.
- Counter widths: bit_cnt is 4 bits; byte_cnt is 8 bits.

Optional Feature:
- Macro: DEFRAMER_PARITY_EN.
- Defined:
  - Each payload byte is followed by one even-parity bit; bit_cnt counts 0..8.
  - byte_valid and byte_out update on the parity-bit edge, not the 8th data bit.
  - parity_err=1 in the same cycle as byte_valid if the XOR of the 8 data bits and the parity bit is 1.
  - The byte is still delivered, and the frame continues.
- Undefined: 8 bits per byte; parity_err is tied to 0.

Decomposition:
- Shared package deframer_pkg:
  - state enum {HUNT, PAYLOAD}
  - BYTE_W=8
  - default SYNC_WORD constant
- One natural sub-module, sipo_byte_collector:
  - An 8-bit serial-in/parallel-out register with a bit counter and a done pulse.
  - Used for both the hunt window and payload assembly.
  - The top level holds the FSM, the fill counter and the byte counter.

Test Plan:
- Reset: assert rst mid-clock, asynchronously -> all outputs 0 before the next edge; locked=0.
- Basic frame: noise bits 1,0,1, then A5, then payload 3C,81,FF,00 (MSB first, din_valid=1 throughout) -> frame_start once after the 8th sync bit; byte_valid x4 with byte_out=3C,81,FF,00; frame_done with the 00 byte; locked falls after it.
- Gapped valid: same stream with din_valid toggled 1,0,1,0 -> identical byte sequence; no strobes on din_valid=0 edges.
- Sync in payload: A5 followed by payload A5,A5,A5,A5 -> exactly one frame_start; four bytes of A5; frame_done; then HUNT.
- Mid-frame reset: rst pulse after 2 payload bytes -> no frame_done; a following full frame A5,11,22,33,44 decodes correctly.
- Parity mode (DEFRAMER_PARITY_EN): payload 3C with parity 0, then 81 with parity 1 (wrong) -> parity_err=0 for 3C and 1 for 81; both bytes delivered.
